// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / divide unit. Works on operand magnitudes for
// 32 radix-2 steps (shift-add or restoring shift-subtract), then applies
// the sign correction in FIX. Every operation takes the same fixed number of cycles.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  opcode,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dzflag
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q;
  logic        is_div_q, neg_res_q, neg_rem_q;
  logic [31:0] a_q;       // raw dividend, returned as remainder on divide by zero
  logic [31:0] m_q;       // |op2|: multiplicand for multiply, divisor for divide
  logic [31:0] acc_hi_q, acc_lo_q;
  logic [31:0] hi_q, lo_q;
  logic        dz_q;

  logic        accept;
  logic        sgn1, sgn2;
  logic [31:0] abs1, abs2;
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic [33:0] div_diff;
  logic        div_ok;
  logic [63:0] prod, prod_fix;
  logic [31:0] quo_fix, rem_fix;
  logic        div_zero;

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  // Next-state logic for the control FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StCalc;
      StCalc: if (cnt_q == 6'd31) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: state_d = accept ? StCalc : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand magnitudes and signs, and the per-step datapath.
  always_comb begin
    sgn1     = opcode[0] & op1[31];
    sgn2     = opcode[0] & op2[31];
    abs1     = sgn1 ? (~op1 + 32'd1) : op1;
    abs2     = sgn2 ? (~op2 + 32'd1) : op2;
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : 33'd0);
    div_sh   = {acc_hi_q, acc_lo_q[31]};
    div_diff = {1'b0, div_sh} - {2'b00, m_q};
    div_ok   = ~div_diff[33];
  end

  // Sign correction applied in FIX.
  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_res_q ? (~prod + 64'd1) : prod;
    quo_fix  = neg_res_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
    rem_fix  = neg_rem_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
    div_zero = is_div_q && (m_q == 32'd0);
  end

  // State, iteration registers and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 6'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= 32'd0;
      m_q       <= 32'd0;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      dz_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q     <= 6'd0;
        is_div_q  <= opcode[1];
        neg_res_q <= sgn1 ^ sgn2;
        neg_rem_q <= sgn1;
        a_q       <= op1;
        m_q       <= abs2;
        acc_hi_q  <= 32'd0;
        acc_lo_q  <= abs1;
      end else if (state_q == StCalc) begin
        cnt_q <= cnt_q + 6'd1;
        if (is_div_q) begin
          acc_hi_q <= div_ok ? div_diff[31:0] : div_sh[31:0];
          acc_lo_q <= {acc_lo_q[30:0], div_ok};
        end else begin
          acc_hi_q <= mul_sum[32:1];
          acc_lo_q <= {mul_sum[0], acc_lo_q[31:1]};
        end
      end else if (state_q == StFix) begin
        cnt_q <= 6'd0;
        dz_q  <= div_zero;
        if (div_zero) begin
          hi_q <= a_q;
          lo_q <= 32'hFFFF_FFFF;
        end else if (is_div_q) begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end else begin
          hi_q <= prod_fix[63:32];
          lo_q <= prod_fix[31:0];
        end
      end
    end
  end

  assign busy   = (state_q == StCalc) || (state_q == StFix);
  assign done   = (state_q == StDone);
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign dzflag = dz_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request; sampled only when the block is idle or in its done cycle.
REQ-005 opcode  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 op1  input  32  multiplicand or dividend.
REQ-007 op2  input  32  multiplier or divisor.
REQ-008 busy  output  1  operation in progress; new starts are ignored while high.
REQ-009 done  output  1  single-cycle completion pulse.
REQ-010 hi  output  32  product[63:32] or remainder.
REQ-011 lo  output  32  product[31:0] or quotient.
REQ-012 dzflag  output  1  last completed divide had a zero divisor.

Function
REQ-013 The block SHALL have the states IDLE, CALC, FIX and DONE.
REQ-014 The block SHALL go from IDLE or DONE to CALC when start=1; op1, op2 and opcode SHALL be latched on that edge (E0).
REQ-015 Changes on op1, op2 or opcode after E0 SHALL NOT affect the running operation.
REQ-016 CALC SHALL perform exactly 32 radix-2 iterations (shift-add for multiply, restoring shift-subtract for divide), one per edge E1..E32, using an internal 6-bit counter.
REQ-017 The block SHALL go from CALC to FIX at E32; FIX SHALL apply sign correction for MULT and DIV and write hi and lo.
REQ-018 The block SHALL go from FIX to DONE at E33; done SHALL be 1 for exactly the one cycle after E33.
REQ-019 After DONE with start=0 the block SHALL go to IDLE; with start=1 it SHALL accept a new operation (back-to-back, REQ-014).
REQ-020 busy SHALL be 1 in CALC and FIX and 0 in IDLE and DONE; busy and done SHALL never both be 1.
REQ-021 start asserted while busy=1 SHALL be ignored and not queued.
REQ-022 hi, lo and dzflag SHALL change only on the FIX-to-DONE edge and hold until the next completion.
REQ-023 MULT/DIV SHALL treat operands as two's complement; MULTU/DIVU SHALL treat them as unsigned.
REQ-024 Multiply: {hi,lo} SHALL be the exact 64-bit product.
REQ-025 Divide: lo SHALL be the quotient truncated toward zero; hi SHALL be the remainder with the dividend's sign, and |hi| < |divisor|.
REQ-026 Divide with op2=0: lo SHALL be 0xFFFFFFFF, hi SHALL be op1 and dzflag=1, with normal latency.
REQ-027 dzflag SHALL be 0 after any multiply or any divide with a nonzero divisor.
REQ-028 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000 with no error indication.
REQ-029 Latency SHALL be fixed at 34 edges from start to done for every opcode and operand value.

Reset
REQ-030 While rst=1 at an edge, the block SHALL enter IDLE with busy=0, done=0, hi=0, lo=0, dzflag=0, counter=0.
REQ-031 rst SHALL take priority over start.
REQ-032 Reset during CALC or FIX SHALL abort the operation; no done pulse SHALL follow and hi/lo SHALL read 0.
REQ-033 A start on the first edge after rst deasserts SHALL be accepted.

Verification
REQ-034 MULTU op1=op2=0xFFFFFFFF -> done 34 edges after start, hi=0xFFFFFFFE, lo=0x00000001, dzflag=0.
REQ-035 MULT op1=0xFFFFFFFD (-3), op2=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV op1=0xFFFFFFF9 (-7), op2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 DIVU op1=0x12345678, op2=0 -> lo=0xFFFFFFFF, hi=0x12345678, dzflag=1; then MULTU 2x3 -> lo=6, hi=0, dzflag=0.
REQ-037 Start DIVU 100/7, pulse start with new operands at E5 and change op1 at E6 -> one done at E34 only, lo=14, hi=2.
REQ-038 Start MULTU, assert rst at E10 -> busy=0, hi=lo=0, no done within 40 cycles; next start completes normally.
REQ-039 Hold start=1 through DONE (back-to-back MULTU 5x5, then DIVU 9/4) -> first done lo=25; second done exactly 34 edges later, lo=2, hi=1.
